// File: rtl/tri_receiver.sv
// Triangle buffer between vertex fetch and the transform pipeline: FWFT FIFO with
// drop flagging, per-object triangle count, and an end-of-object pulse ordered behind the data.
module tri_receiver #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [3:0][2:0][31:0]   tri_in,
  input  logic                    valid_in,
  input  logic                    obj_done_in,
  output logic [3:0][2:0][31:0]   tri_out,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic                    done_out,
  output logic [CNT_W-1:0]        tri_count,
  output logic                    overflow
);

  // state   | meaning
  // IDLE    | object in progress, no end seen yet
  // PENDING | end of object seen, waiting for the FIFO to drain
  // EMIT    | done_out asserted for this single cycle
  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_EMIT} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [3:0][2:0][31:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wp, r_rp;
  logic [AW:0]           r_cnt;
  logic [CNT_W-1:0]      r_tri_count;
  logic                  r_overflow;
  state_t                r_state, w_state_nxt;
  logic                  w_push, w_pop, w_drop;

  assign valid_out = (r_cnt != '0);
  assign w_pop     = valid_out && ready_in;
  assign w_push    = valid_in && ((r_cnt < FULL) || w_pop);
  assign w_drop    = valid_in && (r_cnt == FULL) && !w_pop;
  assign tri_out   = r_mem[r_rp];
  assign tri_count = r_tri_count;
  assign overflow  = r_overflow;

  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wp] <= tri_in;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
      r_tri_count <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
      if (w_drop) r_overflow <= 1'b1;
      // A push landing on the clearing edge is the first triangle of the next object.
      if (r_state == S_EMIT)
        r_tri_count <= w_push ? CNT_W'(1) : '0;
      else if (w_push && (r_tri_count != {CNT_W{1'b1}}))
        r_tri_count <= r_tri_count + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    done_out    = 1'b0;
    case (r_state)
      S_IDLE:    if (obj_done_in) w_state_nxt = S_PENDING;
      S_PENDING: if ((r_cnt == '0) && !w_push) w_state_nxt = S_EMIT;
      S_EMIT: begin
        done_out    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tri_receiver.sv
// Directed bench for tri_receiver: expected triangles are queued when driven and
// compared as the DUT hands them downstream.
module tb_tri_receiver;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
  typedef logic [3:0][2:0][31:0] tri_t;

  logic clk_in = 1'b0, rst_in = 1'b1;
  tri_t tri_in = '0, tri_out;
  logic valid_in = 1'b0, obj_done_in = 1'b0, ready_in = 1'b0;
  logic valid_out, done_out, overflow;
  logic [CNT_W-1:0] tri_count;

  tri_t q[$];
  int checks = 0, errors = 0;
  int cyc = 0, dones = 0, done_cyc = -1, last_pop_cyc = -1, base, k;

  tri_receiver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .tri_in(tri_in), .valid_in(valid_in),
    .obj_done_in(obj_done_in), .tri_out(tri_out), .valid_out(valid_out),
    .ready_in(ready_in), .done_out(done_out), .tri_count(tri_count), .overflow(overflow));

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic tri_t make_tri(input int v);
    tri_t t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        t[r][c] = 32'h1000_0000 + v * 16 + r * 3 + c;
    t[0][0] = v;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input int v, input bit accept);
    tri_in = make_tri(v);
    valid_in = 1'b1;
    if (accept) q.push_back(make_tri(v));
  endtask

  task automatic mid_reset();
    #2 rst_in = 1'b1;
    #1;
    q.delete();
    step();
    rst_in = 1'b0;
    step();
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 64 && q.size() != 0; i++) step();
    chk(tag, 384'(q.size()), 384'(0));
  endtask

  // Scoreboard: a handshake visible at the falling edge completes on the next rising edge.
  always @(negedge clk_in) begin
    if (!rst_in && valid_out && ready_in) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pop got %0h want none", tri_out);
      end
      if (q.size() != 0) chk("pop_data", tri_out, q.pop_front());
      last_pop_cyc = cyc;
    end
    if (!rst_in && done_out) begin
      dones++;
      done_cyc = cyc;
    end
  end

  initial begin
    // reset state
    step();
    chk("rst_valid", 384'(valid_out), 384'(0));
    chk("rst_done", 384'(done_out), 384'(0));
    chk("rst_count", 384'(tri_count), 384'(0));
    chk("rst_ovf", 384'(overflow), 384'(0));
    rst_in = 1'b0;
    repeat (3) step();
    chk("idle_valid", 384'(valid_out), 384'(0));

    // passthrough
    ready_in = 1'b1;
    drive(1, 1); step();
    chk("pt_latency_valid", 384'(valid_out), 384'(1));
    chk("pt_latency_data", 384'(tri_out[0][0]), 384'(1));
    drive(2, 1); step();
    drive(3, 1); step();
    valid_in = 1'b0; step();
    chk("pt_empty", 384'(valid_out), 384'(0));
    chk("pt_count", 384'(tri_count), 384'(3));
    chk("pt_ovf", 384'(overflow), 384'(0));

    // asynchronous reset mid-cycle with data buffered
    ready_in = 1'b0;
    drive(50, 0); step();
    drive(51, 0); step();
    valid_in = 1'b0;
    #2 rst_in = 1'b1;
    #1;
    chk("arst_valid", 384'(valid_out), 384'(0));
    chk("arst_count", 384'(tri_count), 384'(0));
    chk("arst_done", 384'(done_out), 384'(0));
    step(); rst_in = 1'b0;
    repeat (3) step();
    chk("arst_post_valid", 384'(valid_out), 384'(0));

    // fill and drop
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(100 + i, i < DEPTH);
      step();
    end
    valid_in = 1'b0;
    chk("fill_count", 384'(tri_count), 384'(DEPTH));
    chk("fill_ovf", 384'(overflow), 384'(1));
    chk("fill_head", 384'(tri_out[0][0]), 384'(100));
    ready_in = 1'b1;
    wait_empty("fill_drain");
    step();
    chk("fill_drained", 384'(valid_out), 384'(0));
    chk("fill_ovf_sticky", 384'(overflow), 384'(1));

    // full with simultaneous pop
    mid_reset();
    ready_in = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(500 + i, 1);
      step();
    end
    ready_in = 1'b1;
    drive(500 + DEPTH, 1); step();
    valid_in = 1'b0;
    ready_in = 1'b0;
    chk("fp_ovf", 384'(overflow), 384'(0));
    chk("fp_count", 384'(tri_count), 384'(DEPTH + 1));
    chk("fp_head", 384'(tri_out[0][0]), 384'(501));
    ready_in = 1'b1;
    wait_empty("fp_drain");

    // done ordering
    mid_reset();
    ready_in = 1'b0;
    base = dones;
    for (int i = 0; i < 4; i++) begin
      drive(300 + i, 1);
      obj_done_in = (i == 3);
      step();
    end
    valid_in = 1'b0;
    obj_done_in = 1'b0;
    chk("do_count", 384'(tri_count), 384'(4));
    repeat (5) step();
    chk("do_no_early", 384'(dones - base), 384'(0));
    ready_in = 1'b1;
    for (int i = 0; i < 30 && dones == base; i++) step();
    repeat (2) step();
    chk("do_once", 384'(dones - base), 384'(1));
    chk("do_drained", 384'(q.size()), 384'(0));
    chk("do_after_pop", 384'(done_cyc - last_pop_cyc >= 1), 384'(1));
    chk("do_count_clr", 384'(tri_count), 384'(0));

    // second end-of-object on an empty FIFO
    obj_done_in = 1'b1;
    k = cyc;
    step();
    obj_done_in = 1'b0;
    repeat (3) step();
    chk("do2_once", 384'(dones - base), 384'(2));
    chk("do2_latency", 384'(done_cyc - k), 384'(2));

    // reset while PENDING with 2 entries buffered
    ready_in = 1'b0;
    drive(600, 0); step();
    drive(601, 0); step();
    valid_in = 1'b0;
    obj_done_in = 1'b1; step();
    obj_done_in = 1'b0; step();
    base = dones;
    #2 rst_in = 1'b1;
    #1;
    q.delete();
    chk("rp_valid", 384'(valid_out), 384'(0));
    chk("rp_done", 384'(done_out), 384'(0));
    chk("rp_count", 384'(tri_count), 384'(0));
    step(); rst_in = 1'b0;
    ready_in = 1'b1;
    repeat (6) step();
    chk("rp_no_done", 384'(dones - base), 384'(0));
    chk("rp_post_valid", 384'(valid_out), 384'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
